// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU control/status register bank:
// AXI-Lite FSM encodings, register byte offsets and response codes.
package hpu_pkg;

    typedef enum logic [3:0] {
        INI = 4'b0000,
        AW  = 4'b0001,
        W   = 4'b0010,
        AWW = 4'b0011,
        AR1 = 4'b0100,
        AR2 = 4'b1000
    } axil_state_t;

    localparam logic [11:0] REG_CTRL     = 12'h000;
    localparam logic [11:0] REG_STATUS   = 12'h004;
    localparam logic [11:0] REG_ADDR_I   = 12'h008;
    localparam logic [11:0] REG_ADDR_J   = 12'h00C;
    localparam logic [11:0] REG_ITEM_NUM = 12'h010;
    localparam logic [11:0] REG_CORE_EN  = 12'h014;
    localparam logic [11:0] REG_CYCLES   = 12'h018;
    localparam logic [11:0] REG_VERSION  = 12'h01C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Expands the 4-bit byte strobe into a 32-bit bit-enable mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/hpu_ctrl_regs_if.sv
// AXI-Lite slave bus bundle for the HPU control register bank.
interface hpu_ctrl_regs_if;
    // Every channel transfers on the rising edge where valid and ready are both
    // high; valid never waits on ready, and payload is stable while valid is high.
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_fsm.sv
// AXI-Lite handshake engine: captures address/data and issues a one-cycle
// write strobe on entry to AWW and a read strobe during AR1.
module axil_slave_fsm
    import hpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    input  logic [11:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic        rvalid,
    input  logic        rready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    output axil_state_t state
);

    axil_state_t state_q, state_d;
    logic        wr_en_q;
    logic [11:0] wr_addr_q, rd_addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  wr_strb_q;
    logic        ar_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INI;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= (state_d == AWW) && (state_q != AWW);
            if (awvalid && awready) wr_addr_q <= awaddr;
            if (wvalid && wready) begin
                wr_data_q <= wdata;
                wr_strb_q <= wstrb;
            end
            if (ar_take) rd_addr_q <= araddr;
        end
    end

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        ar_take = 1'b0;
        case (state_q)
            INI: begin
                awready = 1'b1;
                wready  = 1'b1;
                arready = 1'b1;
                // A pending write always wins over a simultaneous read.
                if (awvalid && wvalid) state_d = AWW;
                else if (awvalid)      state_d = AW;
                else if (wvalid)       state_d = W;
                else if (arvalid) begin
                    state_d = AR1;
                    ar_take = 1'b1;
                end
            end
            AW: begin
                wready = 1'b1;
                if (wvalid) state_d = AWW;
            end
            W: begin
                awready = 1'b1;
                if (awvalid) state_d = AWW;
            end
            AWW: begin
                bvalid = 1'b1;
                if (bready) state_d = INI;
            end
            AR1: state_d = AR2;
            AR2: begin
                rvalid = 1'b1;
                if (rready) state_d = INI;
            end
            default: state_d = INI;
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_strb = wr_strb_q;
    assign rd_en   = (state_q == AR1);
    assign rd_addr = rd_addr_q;
    assign state   = state_q;

endmodule

// File: rtl/hpu_ctrl_regs.sv
// HPU control/status register bank: programmable kernel parameters, sticky
// done flag, run-cycle counter and per-core enables behind an AXI-Lite slave.
module hpu_ctrl_regs
    import hpu_pkg::*;
#(
    parameter int          ADDR_IJ_W = 20,
    parameter int          ITEM_W    = 16,
    parameter int          NUM_CORE  = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] VERSION   = 32'h0002_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    hpu_ctrl_regs_if.slave       axil,
    input  logic [ITEM_W-1:0]    mat_a,
    input  logic                 get_fin,
    output logic                 matw,
    output logic                 run,
    output logic                 last,
    output logic [ADDR_IJ_W-1:0] addr_i,
    output logic [ADDR_IJ_W-1:0] addr_j,
    output logic [ITEM_W-1:0]    random_num,
    output logic [NUM_CORE-1:0]  core_en,
    output logic                 done,
    output axil_state_t          dbg_state
);

    logic        wr_en, rd_en;
    logic [11:0] wr_addr, rd_addr, wr_off, rd_off;
    logic [31:0] wr_data, bmask;
    logic [3:0]  wr_strb;

    axil_slave_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (axil.awaddr),
        .awvalid (axil.awvalid),
        .awready (axil.awready),
        .wdata   (axil.wdata),
        .wstrb   (axil.wstrb),
        .wvalid  (axil.wvalid),
        .wready  (axil.wready),
        .bvalid  (axil.bvalid),
        .bready  (axil.bready),
        .araddr  (axil.araddr),
        .arvalid (axil.arvalid),
        .arready (axil.arready),
        .rvalid  (axil.rvalid),
        .rready  (axil.rready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .state   (dbg_state)
    );

    assign wr_off = {wr_addr[11:2], 2'b00};
    assign rd_off = {rd_addr[11:2], 2'b00};
    assign bmask  = strb_mask(wr_strb);

    // The whole map lives in the first 32 bytes; anything above is SLVERR.
    assign axil.bresp = (wr_addr[11:5] == '0) ? RESP_OKAY : RESP_SLVERR;

    logic wr_ctrl, wr_status, wr_ai, wr_aj, wr_item, wr_core;
    assign wr_ctrl   = wr_en && (wr_off == REG_CTRL);
    assign wr_status = wr_en && (wr_off == REG_STATUS);
    assign wr_ai     = wr_en && (wr_off == REG_ADDR_I);
    assign wr_aj     = wr_en && (wr_off == REG_ADDR_J);
    assign wr_item   = wr_en && (wr_off == REG_ITEM_NUM);
    assign wr_core   = wr_en && (wr_off == REG_CORE_EN);

    logic [2:0] ctrl_cur, ctrl_new;
    logic       run_rise, w1c_done;
    logic [CNT_W-1:0] cycles;

    assign ctrl_cur = {last, run, matw};
    assign ctrl_new = (ctrl_cur & ~bmask[2:0]) | (wr_data[2:0] & bmask[2:0]);
    assign run_rise = wr_ctrl && !run && ctrl_new[1];
    assign w1c_done = wr_status && wr_strb[0] && wr_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            matw       <= 1'b0;
            run        <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
            addr_i     <= '0;
            addr_j     <= '0;
            random_num <= '0;
            core_en    <= '1;
            cycles     <= '0;
        end else begin
            // A software CTRL write overrides the item-memory auto-stop.
            if (wr_ctrl) begin
                matw <= ctrl_new[0];
                run  <= ctrl_new[1];
                last <= ctrl_new[2];
            end else if (matw && (mat_a == random_num)) begin
                matw <= 1'b0;
            end

            if (run && get_fin)           done <= 1'b1;
            else if (run_rise || w1c_done) done <= 1'b0;

            if (run_rise)                           cycles <= '0;
            else if (run && !done && !(&cycles))    cycles <= cycles + CNT_W'(1);

            if (wr_ai)
                addr_i <= (addr_i & ~bmask[ADDR_IJ_W-1:0]) | (wr_data[ADDR_IJ_W-1:0] & bmask[ADDR_IJ_W-1:0]);
            if (wr_aj)
                addr_j <= (addr_j & ~bmask[ADDR_IJ_W-1:0]) | (wr_data[ADDR_IJ_W-1:0] & bmask[ADDR_IJ_W-1:0]);
            if (wr_item)
                random_num <= (random_num & ~bmask[ITEM_W-1:0]) | (wr_data[ITEM_W-1:0] & bmask[ITEM_W-1:0]);
            if (wr_core)
                core_en <= (core_en & ~bmask[NUM_CORE-1:0]) | (wr_data[NUM_CORE-1:0] & bmask[NUM_CORE-1:0]);
        end
    end

    logic [31:0] rd_word, rdata_q;
    logic        rd_ok;
    logic [1:0]  rresp_q;

    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b1;
        case (rd_off)
            REG_CTRL:     rd_word = 32'(ctrl_cur);
            REG_STATUS:   rd_word = 32'({matw, done});
            REG_ADDR_I:   rd_word = 32'(addr_i);
            REG_ADDR_J:   rd_word = 32'(addr_j);
            REG_ITEM_NUM: rd_word = 32'(random_num);
            REG_CORE_EN:  rd_word = 32'(core_en);
            REG_CYCLES:   rd_word = 32'(cycles);
            REG_VERSION:  rd_word = VERSION;
            default:      rd_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (rd_en) begin
            rdata_q <= rd_word;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign axil.rdata = rdata_q;
    assign axil.rresp = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{wr_data, bmask, rd_addr[1:0]};

endmodule

// File: tb/tb_hpu_ctrl_regs.sv
// Self-checking bench for hpu_ctrl_regs: directed scenarios plus randomized
// register traffic checked against a byte-level model of the register map.
module tb_hpu_ctrl_regs;

    localparam int ADDR_IJ_W = 20;
    localparam int ITEM_W    = 16;
    localparam int NUM_CORE  = 4;
    localparam int CNT_W     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ITEM_W-1:0]    mat_a;
    logic                 get_fin;
    logic                 matw, run, last, done;
    logic [ADDR_IJ_W-1:0] addr_i, addr_j;
    logic [ITEM_W-1:0]    random_num;
    logic [NUM_CORE-1:0]  core_en;
    hpu_pkg::axil_state_t dbg_state;

    hpu_ctrl_regs_if bus ();

    hpu_ctrl_regs #(
        .ADDR_IJ_W (ADDR_IJ_W),
        .ITEM_W    (ITEM_W),
        .NUM_CORE  (NUM_CORE),
        .CNT_W     (CNT_W),
        .VERSION   (32'h0002_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axil       (bus),
        .mat_a      (mat_a),
        .get_fin    (get_fin),
        .matw       (matw),
        .run        (run),
        .last       (last),
        .addr_i     (addr_i),
        .addr_j     (addr_j),
        .random_num (random_num),
        .core_en    (core_en),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    logic [31:0] m_addr_i, m_addr_j, m_item, m_core, m_cycles;
    logic        m_matw, m_run, m_last, m_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_addr_i = 0; m_addr_j = 0; m_item = 0; m_core = 32'hF; m_cycles = 0;
        m_matw = 0; m_run = 0; m_last = 0; m_done = 0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic fin);
        logic [31:0] nv;
        case ({a[11:2], 2'b00})
            12'h000: begin
                nv = merge_bytes({29'd0, m_last, m_run, m_matw}, d, s);
                if (!m_run && nv[1]) begin
                    m_done   = 1'b0;
                    m_cycles = 0;
                end
                m_matw = nv[0]; m_run = nv[1]; m_last = nv[2];
            end
            12'h004: if (s[0] && d[0] && !(fin && m_run)) m_done = 1'b0;
            12'h008: m_addr_i = merge_bytes(m_addr_i, d, s) & 32'h000F_FFFF;
            12'h00C: m_addr_j = merge_bytes(m_addr_j, d, s) & 32'h000F_FFFF;
            12'h010: m_item   = merge_bytes(m_item, d, s) & 32'h0000_FFFF;
            12'h014: m_core   = merge_bytes(m_core, d, s) & 32'h0000_000F;
            default: ;
        endcase
        if (fin && m_run) m_done = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case ({a[11:2], 2'b00})
            12'h000: return {29'd0, m_last, m_run, m_matw};
            12'h004: return {30'd0, m_matw, m_done};
            12'h008: return m_addr_i;
            12'h00C: return m_addr_j;
            12'h010: return m_item;
            12'h014: return m_core;
            12'h018: return m_cycles;
            12'h01C: return 32'h0002_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] exp_resp(input logic [11:0] a);
        return (a < 12'h020) ? 2'b00 : 2'b10;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_d, input int w_d, input logic fin);
        logic aw_pend, w_pend, aw_hs, w_hs;
        int cyc;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        aw_pend = 1; w_pend = 1; cyc = 0;
        while ((aw_pend || w_pend) && cyc < 40) begin
            if (aw_pend && cyc >= aw_d) bus.awvalid = 1'b1;
            if (w_pend && cyc >= w_d)   bus.wvalid  = 1'b1;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_pend  = 1'b0; end
        end
        check_eq("wr_handshake_done", {31'd0, aw_pend | w_pend}, 32'd0);
        cyc = 0;
        while (!bus.bvalid && cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("bvalid_seen", {31'd0, bus.bvalid}, 32'd1);
        check_eq("bresp", {30'd0, bus.bresp}, {30'd0, exp_resp(a)});
        get_fin = fin;
        @(posedge clk); #1;
        get_fin = 1'b0;
        model_write(a, d, s, fin);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] data, output logic [1:0] resp);
        int lat;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
        lat = 0;
        while (!bus.arready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("rd_latency", 32'(lat), 32'd2);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        exp_q.push_back(model_read(a));
        axi_read(a, d, r);
        check_eq({tag, "_rdata"}, d, exp_q.pop_front());
        check_eq({tag, "_rresp"}, {30'd0, r}, {30'd0, exp_resp(a)});
    endtask

    task automatic check_ports(input string tag);
        check_eq({tag, "_matw"},    {31'd0, matw},   {31'd0, m_matw});
        check_eq({tag, "_run"},     {31'd0, run},    {31'd0, m_run});
        check_eq({tag, "_last"},    {31'd0, last},   {31'd0, m_last});
        check_eq({tag, "_done"},    {31'd0, done},   {31'd0, m_done});
        check_eq({tag, "_addr_i"},  32'(addr_i),     m_addr_i);
        check_eq({tag, "_addr_j"},  32'(addr_j),     m_addr_j);
        check_eq({tag, "_item"},    32'(random_num), m_item);
        check_eq({tag, "_core_en"}, 32'(core_en),    m_core);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          sel;
        logic [11:0] a;

        bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 1; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
        mat_a = 0; get_fin = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_ports("rst");
        check_eq("rst_awready", {31'd0, bus.awready}, 32'd1);
        check_eq("rst_wready",  {31'd0, bus.wready},  32'd1);
        check_eq("rst_arready", {31'd0, bus.arready}, 32'd1);
        check_eq("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
        check_eq("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
        check_eq("rst_rdata",   bus.rdata,            32'd0);
        check_eq("rst_state",   32'(dbg_state),       32'(hpu_pkg::INI));
        rd_check("core_en_rst", 12'h014);
        rd_check("version",     12'h01C);
        rd_check("ctrl_rst",    12'h000);

        // AW leads W by three cycles; byte-strobe masking
        axi_write(12'h008, 32'h0000_012B, 4'hF, 0, 3, 1'b0);
        rd_check("addr_i_split", 12'h008);
        axi_write(12'h00C, 32'hFFFF_FFFF, 4'h1, 0, 0, 1'b0);
        rd_check("addr_j_strb", 12'h00C);
        axi_write(12'h010, 32'hABCD_1234, 4'hF, 2, 0, 1'b0);
        rd_check("item_w_first", 12'h010);

        // Randomized register traffic
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: a = 12'h008;
                1: a = 12'h00C;
                2: a = 12'h010;
                3: a = 12'h014;
                4: a = 12'h018;
                5: a = 12'h01C;
                6: a = 12'h000;
                default: a = 12'($urandom_range(8, 1023) * 4);
            endcase
            a = a | 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1 && sel != 6)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
            else
                rd_check("rnd", a);
        end
        check_ports("rnd");

        // Item-memory generation stops when mat_a reaches ITEM_NUM
        axi_write(12'h010, 32'd100, 4'hF, 0, 0, 1'b0);
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, 1'b0);
        check_eq("matw_set", {31'd0, matw}, 32'd1);
        for (int i = 0; i <= 105; i++) begin
            if (i >= 97) check_eq($sformatf("matw_i%0d", i), {31'd0, matw}, {31'd0, i <= 100});
            mat_a = ITEM_W'(i);
            @(posedge clk); #1;
        end
        mat_a = 0;
        m_matw = 1'b0;
        rd_check("status_matw", 12'h004);

        // Run, completion pulse, cycle count and sticky done
        axi_write(12'h000, 32'h2, 4'hF, 0, 0, 1'b0);
        repeat (49) @(posedge clk);
        #1 get_fin = 1'b1;
        @(posedge clk); #1;
        get_fin = 1'b0;
        m_done = 1'b1;
        m_cycles = 50;
        check_eq("done_set", {31'd0, done}, 32'd1);
        rd_check("status_done", 12'h004);
        rd_check("cycles_50", 12'h018);
        repeat (5) @(posedge clk);
        #1 rd_check("cycles_hold", 12'h018);
        axi_write(12'h004, 32'h1, 4'hF, 0, 0, 1'b0);
        check_eq("done_w1c", {31'd0, done}, {31'd0, m_done});
        axi_write(12'h004, 32'h1, 4'hF, 0, 0, 1'b1);
        check_eq("done_set_wins", {31'd0, done}, 32'd1);
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, 1'b0);
        axi_write(12'h000, 32'h2, 4'hF, 0, 0, 1'b0);
        check_eq("done_run_rise", {31'd0, done}, 32'd0);
        m_cycles = 1;
        rd_check("cycles_restart", 12'h018);
        axi_write(12'h000, 32'h4, 4'hF, 0, 0, 1'b0);
        check_ports("ctrl_last");

        // Unmapped offsets
        axi_read(12'h040, d, r);
        check_eq("unmapped_rdata", d, 32'd0);
        check_eq("unmapped_rresp", {30'd0, r}, 32'd2);
        axi_write(12'h044, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0);
        rd_check("post_err_ai",   12'h008);
        rd_check("post_err_aj",   12'h00C);
        rd_check("post_err_item", 12'h010);
        rd_check("post_err_core", 12'h014);

        // Reset while a read response is stalled in AR2
        axi_write(12'h008, 32'h000A_5A5A, 4'hF, 0, 0, 1'b0);
        bus.araddr = 12'h008; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(posedge clk); #1;
        check_eq("ar2_rvalid", {31'd0, bus.rvalid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_eq("rst_mid_rvalid",  {31'd0, bus.rvalid},  32'd0);
        check_eq("rst_mid_arready", {31'd0, bus.arready}, 32'd1);
        check_eq("rst_mid_rdata",   bus.rdata,            32'd0);
        check_ports("rst_mid");
        rd_check("rst_mid_ai",     12'h008);
        rd_check("rst_mid_core",   12'h014);
        rd_check("rst_mid_cycles", 12'h018);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
